// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
//   Shared types and constants for the multiplexed hex display driver.
//
//   Contents:
//     NUM_DIGITS    number of display digits scanned per frame
//     nibble_t      4-bit value shown on one digit
//     seg7_t        7 segment lines, bit 0 = a .. bit 6 = g
//     HEX_GLYPH     active-high glyphs for the hex values 0..F
//     digit_onehot  active-high one-hot digit select for a digit index
// ---------------------------------------------------------------------------
package display_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [3:0] nibble_t;
   typedef logic [6:0] seg7_t;

   // Glyphs are stored active-high with bit 0 = segment a. Lower-case
   // shapes are used for b and d so they cannot be confused with 8 and 0.
   localparam seg7_t HEX_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Active-high one-hot enable for the digit at position idx.
   function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] idx);
      logic [NUM_DIGITS-1:0] sel;
      sel = '0;
      sel[idx] = 1'b1;
      return sel;
   endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// ---------------------------------------------------------------------------
// hex7seg_decoder
//   Purely combinational hex-to-seven-segment lookup. The output is always
//   active-high; the display polarity is applied by the instantiating block.
//
//   Ports:
//     value  in   4  nibble to display
//     glyph  out  7  active-high segment pattern, bit 0 = a .. bit 6 = g
// ---------------------------------------------------------------------------
module hex7seg_decoder
   import display_pkg::*;
(
   input  nibble_t value,
   output seg7_t   glyph
);

   assign glyph = HEX_GLYPH[value];

endmodule

// File: rtl/arr_display_scan.sv
// ---------------------------------------------------------------------------
// arr_display_scan
//   Time-multiplexed 4-digit hex display driver. Each digit owns a slot of
//   TICK_DIV clocks, the first BLANK_CYCLES of which keep every digit dark
//   to avoid ghosting between neighbouring digits. All four input values
//   are captured together once per frame (4 slots) so a frame never mixes
//   old and new data.
//
//   Parameters:
//     TICK_DIV        clocks per digit slot (>= 2)
//     BLANK_CYCLES    dark clocks at the start of each slot (0..TICK_DIV-1)
//     SEG_ACTIVE_LOW  1 = segment lines are active-low
//     AN_ACTIVE_LOW   1 = digit enables are active-low
//
//   Ports:
//     clk          in   1  core clock
//     reset        in   1  asynchronous reset, active-low
//     arr0..arr3   in   4  values for digit 0 (rightmost) .. digit 3
//     freeze       in   1  holds the current snapshot at frame boundaries
//     seg          out  7  segment drive, seg[0] = a .. seg[6] = g
//     an           out  4  one-hot digit enable, an[i] = digit i
//     frame_start  out  1  one-clock pulse when a new frame begins
// ---------------------------------------------------------------------------
module arr_display_scan
   import display_pkg::*;
#(
   parameter int TICK_DIV       = 1000,
   parameter int BLANK_CYCLES   = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] arr0,
   input  logic [3:0] arr1,
   input  logic [3:0] arr2,
   input  logic [3:0] arr3,
   input  logic       freeze,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       frame_start
);

   localparam int                CNT_W   = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

   // "Everything dark" values at the configured pad polarity.
   localparam seg7_t                 SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   nibble_t          snap [NUM_DIGITS];
   logic             primed;

   nibble_t          arr_vec [NUM_DIGITS];
   logic             slot_end;
   logic             frame_end;
   logic             capture;
   logic             blank;
   seg7_t            glyph;
   seg7_t            seg_next;
   logic [NUM_DIGITS-1:0] an_next;

   assign arr_vec[0] = arr0;
   assign arr_vec[1] = arr1;
   assign arr_vec[2] = arr2;
   assign arr_vec[3] = arr3;

   // A frame ends on the last clock of digit 3's slot. The very first clock
   // after reset also captures (primed low), regardless of freeze, so the
   // display never comes up showing the all-zero reset snapshot.
   assign slot_end  = (cnt == CNT_MAX);
   assign frame_end = slot_end && (idx == 2'd3);
   assign capture   = !primed || (frame_end && !freeze);

   assign blank = (int'(cnt) < BLANK_CYCLES);

   hex7seg_decoder u_decoder (
      .value (snap[idx]),
      .glyph (glyph)
   );

   // Polarity is applied here so the decoder stays display-agnostic.
   always_comb begin
      seg_next = SEG_OFF;
      an_next  = AN_OFF;
      if (!blank) begin
         seg_next = SEG_ACTIVE_LOW ? ~glyph : glyph;
         an_next  = AN_ACTIVE_LOW ? ~digit_onehot(idx) : digit_onehot(idx);
      end
   end

   // Slot counter and digit index: idx advances once per completed slot
   // and wraps naturally from 3 to 0 through its 2-bit width.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Snapshot registers. frame_start marks every frame boundary, including
   // frozen ones, so downstream logic can stay frame-aligned while frozen.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         primed      <= 1'b0;
         frame_start <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            snap[i] <= '0;
         end
      end else begin
         primed      <= 1'b1;
         frame_start <= !primed || frame_end;
         if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               snap[i] <= arr_vec[i];
            end
         end
      end
   end

   // Registered pad drivers keep the outputs glitch-free; they lag the scan
   // state by one clock and go dark immediately on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg <= SEG_OFF;
         an  <= AN_OFF;
      end else begin
         seg <= seg_next;
         an  <= an_next;
      end
   end

endmodule

// File: tb/tb_arr_display_scan.sv
// ---------------------------------------------------------------------------
// tb_arr_display_scan
//   Self-checking bench for arr_display_scan with TICK_DIV=4, BLANK_CYCLES=1
//   and active-low segments and digit enables. A reference model counts
//   clock edges since reset release and derives the expected slot, blanking
//   and frame boundaries arithmetically from that count.
// ---------------------------------------------------------------------------
module tb_arr_display_scan;

   localparam int TD    = 4;
   localparam int BLANK = 1;
   localparam int FRAME = 4 * TD;

   logic       clk;
   logic       reset;
   logic [3:0] arr0, arr1, arr2, arr3;
   logic       freeze;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame_start;

   int checks = 0;
   int fails  = 0;

   // Reference model state
   int         k;
   logic [3:0] model_snap [4];
   logic [3:0] exp_an;
   logic [6:0] exp_seg;
   logic       exp_fs;

   logic [6:0] glyph_tb [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   arr_display_scan #(
      .TICK_DIV       (TD),
      .BLANK_CYCLES   (BLANK),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .arr0        (arr0),
      .arr1        (arr1),
      .arr2        (arr2),
      .arr3        (arr3),
      .freeze      (freeze),
      .seg         (seg),
      .an          (an),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advances one clock and produces the expected outputs for edge k.
   // The output after edge k reflects scan position k-1, using the snapshot
   // held before that edge; captures happen at edge 1 and every FRAME edges.
   task automatic advance();
      logic [3:0] a [4];
      logic       fz;
      int         p, slot, pos;
      bit         ev_a, ev_b;
      a[0] = arr0; a[1] = arr1; a[2] = arr2; a[3] = arr3;
      fz = freeze;
      @(posedge clk);
      #1;
      k++;
      p    = k - 1;
      slot = (p / TD) % 4;
      pos  = p % TD;
      if (pos < BLANK) begin
         exp_an  = 4'hF;
         exp_seg = 7'h7F;
      end else begin
         exp_an  = ~(4'b0001 << slot);
         exp_seg = ~glyph_tb[model_snap[slot]];
      end
      ev_a   = (k == 1);
      ev_b   = (k % FRAME == 0);
      exp_fs = ev_a || ev_b;
      if (ev_a || (ev_b && !fz)) begin
         for (int i = 0; i < 4; i++) model_snap[i] = a[i];
      end
   endtask

   task automatic applyStimulus(input logic [3:0] v0, v1, v2, v3, input logic fz);
      arr0 = v0; arr1 = v1; arr2 = v2; arr3 = v3;
      freeze = fz;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      k = 0;
      for (int i = 0; i < 4; i++) model_snap[i] = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      checks += 3;
      if (an !== 4'hF) begin fails++; $display("[TB] FAIL reset_an: got %b expected 1111", an); end
      if (seg !== 7'h7F) begin fails++; $display("[TB] FAIL reset_seg: got %b expected 1111111", seg); end
      if (frame_start !== 1'b0) begin fails++; $display("[TB] FAIL reset_fs: got %b expected 0", frame_start); end
      @(negedge clk);
      reset = 1'b1;
      advance();
      checks += 2;
      if (frame_start !== 1'b1) begin fails++; $display("[TB] FAIL release_fs: got %b expected 1", frame_start); end
      if (an !== 4'hF) begin fails++; $display("[TB] FAIL release_an: got %b expected 1111", an); end
   endtask

   task automatic test_scan();
      logic [3:0] fixed_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [6:0] fixed_seg [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
      repeat (2 * FRAME) begin
         advance();
         checks += 4;
         if (an !== exp_an) begin fails++; $display("[TB] FAIL scan_an k=%0d: got %b expected %b", k, an, exp_an); end
         if (seg !== exp_seg) begin fails++; $display("[TB] FAIL scan_seg k=%0d: got %b expected %b", k, seg, exp_seg); end
         if (frame_start !== exp_fs) begin fails++; $display("[TB] FAIL scan_fs k=%0d: got %b expected %b", k, frame_start, exp_fs); end
         if ($countones(~an) > 1) begin fails++; $display("[TB] FAIL scan_onehot k=%0d: got %b expected at most one low", k, an); end
         // Spec-listed patterns for the second clock of each slot
         if (k <= FRAME && (k - 1) % TD == 1) begin
            checks += 2;
            if (an !== fixed_an[(k - 1) / TD]) begin fails++; $display("[TB] FAIL scan_fixed_an k=%0d: got %b expected %b", k, an, fixed_an[(k - 1) / TD]); end
            if (seg !== fixed_seg[(k - 1) / TD]) begin fails++; $display("[TB] FAIL scan_fixed_seg k=%0d: got %b expected %b", k, seg, fixed_seg[(k - 1) / TD]); end
         end
      end
   endtask

   task automatic test_coherence();
      int guard = 0;
      while (((k / TD) % 4) != 1 && guard < FRAME) begin
         advance();
         guard++;
      end
      arr0 = 4'hF;
      repeat (2 * FRAME) begin
         advance();
         checks += 3;
         if (an !== exp_an) begin fails++; $display("[TB] FAIL coherence_an k=%0d: got %b expected %b", k, an, exp_an); end
         if (seg !== exp_seg) begin fails++; $display("[TB] FAIL coherence_seg k=%0d: got %b expected %b", k, seg, exp_seg); end
         if (frame_start !== exp_fs) begin fails++; $display("[TB] FAIL coherence_fs k=%0d: got %b expected %b", k, frame_start, exp_fs); end
      end
   endtask

   task automatic test_freeze();
      int guard = 0;
      while ((k % FRAME) != 8 && guard < FRAME) begin
         advance();
         guard++;
      end
      freeze = 1'b1;
      arr0   = 4'd8;
      repeat (FRAME) begin
         advance();
         checks += 3;
         if (an !== exp_an) begin fails++; $display("[TB] FAIL freeze_an k=%0d: got %b expected %b", k, an, exp_an); end
         if (seg !== exp_seg) begin fails++; $display("[TB] FAIL freeze_seg k=%0d: got %b expected %b", k, seg, exp_seg); end
         if (frame_start !== exp_fs) begin fails++; $display("[TB] FAIL freeze_fs k=%0d: got %b expected %b", k, frame_start, exp_fs); end
      end
      freeze = 1'b0;
      repeat (2 * FRAME) begin
         advance();
         checks += 3;
         if (an !== exp_an) begin fails++; $display("[TB] FAIL unfreeze_an k=%0d: got %b expected %b", k, an, exp_an); end
         if (seg !== exp_seg) begin fails++; $display("[TB] FAIL unfreeze_seg k=%0d: got %b expected %b", k, seg, exp_seg); end
         if (frame_start !== exp_fs) begin fails++; $display("[TB] FAIL unfreeze_fs k=%0d: got %b expected %b", k, frame_start, exp_fs); end
      end
   endtask

   task automatic test_async_reset();
      int guard = 0;
      // Stop where the scan state is cnt=2 of digit 2
      while ((k % FRAME) != 10 && guard < FRAME) begin
         advance();
         guard++;
      end
      applyStimulus(4'h5, 4'h6, 4'h7, 4'h9, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      checks += 3;
      if (an !== 4'hF) begin fails++; $display("[TB] FAIL async_an: got %b expected 1111", an); end
      if (seg !== 7'h7F) begin fails++; $display("[TB] FAIL async_seg: got %b expected 1111111", seg); end
      if (frame_start !== 1'b0) begin fails++; $display("[TB] FAIL async_fs: got %b expected 0", frame_start); end
      @(negedge clk);
      reset = 1'b1;
      k = 0;
      for (int i = 0; i < 4; i++) model_snap[i] = 4'd0;
      repeat (FRAME + 4) begin
         advance();
         checks += 3;
         if (an !== exp_an) begin fails++; $display("[TB] FAIL post_reset_an k=%0d: got %b expected %b", k, an, exp_an); end
         if (seg !== exp_seg) begin fails++; $display("[TB] FAIL post_reset_seg k=%0d: got %b expected %b", k, seg, exp_seg); end
         if (frame_start !== exp_fs) begin fails++; $display("[TB] FAIL post_reset_fs k=%0d: got %b expected %b", k, frame_start, exp_fs); end
      end
   endtask

   task automatic test_glyph_sweep();
      for (int v = 0; v < 16; v++) begin
         applyStimulus(4'(v), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 1'b0);
         repeat (FRAME) begin
            advance();
            checks += 2;
            if (an !== exp_an) begin fails++; $display("[TB] FAIL glyph_an v=%0d k=%0d: got %b expected %b", v, k, an, exp_an); end
            if (seg !== exp_seg) begin fails++; $display("[TB] FAIL glyph_seg v=%0d k=%0d: got %b expected %b", v, k, seg, exp_seg); end
         end
      end
   endtask

   task automatic test_random();
      repeat (20 * FRAME) begin
         applyStimulus(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                       ($urandom_range(0, 3) == 0));
         advance();
         checks += 4;
         if (an !== exp_an) begin fails++; $display("[TB] FAIL random_an k=%0d: got %b expected %b", k, an, exp_an); end
         if (seg !== exp_seg) begin fails++; $display("[TB] FAIL random_seg k=%0d: got %b expected %b", k, seg, exp_seg); end
         if (frame_start !== exp_fs) begin fails++; $display("[TB] FAIL random_fs k=%0d: got %b expected %b", k, frame_start, exp_fs); end
         if ($countones(~an) > 1) begin fails++; $display("[TB] FAIL random_onehot k=%0d: got %b expected at most one low", k, an); end
      end
   endtask

   initial begin
      $display("[TB] arr_display_scan bench start");
      test_reset();
      test_scan();
      test_coherence();
      test_freeze();
      test_async_reset();
      test_glyph_sweep();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
